// File: rtl/aes_sbox_pkg.sv
// Shared types and constants for the AES S-box table controller.
package aes_sbox_pkg;

  localparam int SBOX_DEPTH = 256;
  localparam int SBOX_AW    = 8;

  typedef enum logic [2:0] {
    LOAD,
    IDLE,
    LOOKUP,
    CAPTURE,
    RESP
  } sbox_state_e;

  typedef enum logic {
    REQ_K,
    REQ_R
  } req_id_e;

endpackage

// File: rtl/sbox_arb2.sv
// Two-way grant between key-expansion (K) and round (R) requesters.
// SBOX_RR_ARB_EN selects round-robin; otherwise K has fixed priority.
module sbox_arb2
  import aes_sbox_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic k_valid_i,
  input  logic r_valid_i,
  input  logic take_i,
  output logic k_grant_o,
  output logic r_grant_o
);

`ifdef SBOX_RR_ARB_EN
  req_id_e last_q;

  // On a tie, whoever was not served last wins.
  always_comb begin
    k_grant_o = k_valid_i & (~r_valid_i | (last_q == REQ_R));
    r_grant_o = r_valid_i & (~k_valid_i | (last_q == REQ_K));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= REQ_R;
    end else if (take_i) begin
      last_q <= k_grant_o ? REQ_K : REQ_R;
    end
  end
`else
  logic unused_arb;

  always_comb begin
    k_grant_o = k_valid_i;
    r_grant_o = r_valid_i & ~k_valid_i;
  end

  assign unused_arb = clk ^ rst_n ^ take_i;
`endif

endmodule

// File: rtl/sbox_sched.sv
// S-box table controller: streams the table into the ROM after reset, then
// serves 4-byte SubWord lookups for K and R (arbitration: see SBOX_RR_ARB_EN).
//
// state   | meaning
// LOAD    | accepting table bytes, writing ROM addresses 0..255
// IDLE    | table loaded, waiting for a granted request
// LOOKUP  | rom_rd_en asserted for one cycle
// CAPTURE | waiting for rom_done, then latching the owner's response word
// RESP    | owner's rsp_valid pulse
module sbox_sched
  import aes_sbox_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ld_valid,
  input  logic [7:0]          ld_data,
  output logic                ld_ready,
  output logic                loaded,
  input  logic                k_req_valid,
  input  logic [31:0]         k_req_word,
  output logic                k_req_ready,
  output logic                k_rsp_valid,
  output logic [31:0]         k_rsp_word,
  input  logic                r_req_valid,
  input  logic [31:0]         r_req_word,
  output logic                r_req_ready,
  output logic                r_rsp_valid,
  output logic [31:0]         r_rsp_word,
  output logic                rom_rst,
  output logic                rom_wr_en,
  output logic [SBOX_AW-1:0]  rom_addr,
  output logic [7:0]          rom_in,
  output logic                rom_rd_en,
  output logic [SBOX_AW-1:0]  rom_addr0,
  output logic [SBOX_AW-1:0]  rom_addr1,
  output logic [SBOX_AW-1:0]  rom_addr2,
  output logic [SBOX_AW-1:0]  rom_addr3,
  input  logic [7:0]          rom_out0,
  input  logic [7:0]          rom_out1,
  input  logic [7:0]          rom_out2,
  input  logic [7:0]          rom_out3,
  input  logic                rom_done
);

  localparam logic [SBOX_AW-1:0] LAST_ADDR = SBOX_AW'(SBOX_DEPTH - 1);

  sbox_state_e             state_q;
  logic [SBOX_AW-1:0]      cnt_q;
  logic                    loaded_q;
  logic                    rom_rst_q;
  logic                    rom_wr_en_q;
  logic [SBOX_AW-1:0]      rom_addr_q;
  logic [7:0]              rom_in_q;
  logic                    rom_rd_en_q;
  logic [3:0][SBOX_AW-1:0] rd_addr_q;
  req_id_e                 owner_q;
  logic                    k_rsp_valid_q;
  logic                    r_rsp_valid_q;
  logic [31:0]             k_rsp_word_q;
  logic [31:0]             r_rsp_word_q;

  logic k_grant;
  logic r_grant;
  logic ld_accept;
  logic req_open;
  logic req_take;

  sbox_arb2 u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .k_valid_i (k_req_valid),
    .r_valid_i (r_req_valid),
    .take_i    (req_take),
    .k_grant_o (k_grant),
    .r_grant_o (r_grant)
  );

  assign ld_ready    = (state_q == LOAD) & ~rom_rst_q;
  assign ld_accept   = ld_ready & ld_valid;
  assign req_open    = (state_q == IDLE) & loaded_q;
  assign k_req_ready = req_open & k_grant;
  assign r_req_ready = req_open & r_grant;
  assign req_take    = (k_req_ready & k_req_valid) | (r_req_ready & r_req_valid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= LOAD;
      cnt_q         <= '0;
      loaded_q      <= 1'b0;
      rom_rst_q     <= 1'b1;
      rom_wr_en_q   <= 1'b0;
      rom_addr_q    <= '0;
      rom_in_q      <= '0;
      rom_rd_en_q   <= 1'b0;
      rd_addr_q     <= '0;
      owner_q       <= REQ_K;
      k_rsp_valid_q <= 1'b0;
      r_rsp_valid_q <= 1'b0;
      k_rsp_word_q  <= '0;
      r_rsp_word_q  <= '0;
    end else begin
      rom_rst_q     <= 1'b0;
      rom_wr_en_q   <= 1'b0;
      k_rsp_valid_q <= 1'b0;
      r_rsp_valid_q <= 1'b0;
      case (state_q)
        LOAD: begin
          if (ld_accept) begin
            rom_wr_en_q <= 1'b1;
            rom_addr_q  <= cnt_q;
            rom_in_q    <= ld_data;
            cnt_q       <= cnt_q + 1'b1;
            if (cnt_q == LAST_ADDR) begin
              loaded_q <= 1'b1;
              state_q  <= IDLE;
            end
          end
        end
        IDLE: begin
          if (req_take) begin
            rd_addr_q   <= k_req_ready ? k_req_word : r_req_word;
            owner_q     <= k_req_ready ? REQ_K : REQ_R;
            rom_rd_en_q <= 1'b1;
            state_q     <= LOOKUP;
          end
        end
        LOOKUP: begin
          rom_rd_en_q <= 1'b0;
          state_q     <= CAPTURE;
        end
        CAPTURE: begin
          if (rom_done) begin
            if (owner_q == REQ_K) begin
              k_rsp_word_q  <= {rom_out3, rom_out2, rom_out1, rom_out0};
              k_rsp_valid_q <= 1'b1;
            end else begin
              r_rsp_word_q  <= {rom_out3, rom_out2, rom_out1, rom_out0};
              r_rsp_valid_q <= 1'b1;
            end
            state_q <= RESP;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= LOAD;
        end
      endcase
    end
  end

  assign loaded      = loaded_q;
  assign rom_rst     = rom_rst_q;
  assign rom_wr_en   = rom_wr_en_q;
  assign rom_addr    = rom_addr_q;
  assign rom_in      = rom_in_q;
  assign rom_rd_en   = rom_rd_en_q;
  assign rom_addr0   = rd_addr_q[0];
  assign rom_addr1   = rd_addr_q[1];
  assign rom_addr2   = rd_addr_q[2];
  assign rom_addr3   = rd_addr_q[3];
  assign k_rsp_valid = k_rsp_valid_q;
  assign r_rsp_valid = r_rsp_valid_q;
  assign k_rsp_word  = k_rsp_word_q;
  assign r_rsp_word  = r_rsp_word_q;

endmodule
